// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: reset sequencing, key debounce and run/halt/timeout control
// for the pipelined RISC-V core.
// Optional feature macro: RUN_CTRL_RESTART_EN (debounced press on key 0
// restarts the run from RUN, DONE or TIMEOUT).

// Per-channel two-flop synchroniser plus debounce counter.
module riscv_run_ctrl_deb #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key,
  output logic key_pulse
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after DEB_CYCLES mismatching edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      key       <= 1'b0;
      key_pulse <= 1'b0;
      cnt       <= '0;
    end else begin
      s1        <= key_raw;
      s2        <= s1;
      key_pulse <= 1'b0;
      if (s2 == key) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        key       <= s2;
        key_pulse <= s2;   // pulse only when the accepted level is 1
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module riscv_run_ctrl #(
  parameter int KEY_CH     = 4,
  parameter int DEB_CYCLES = 8,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_CH-1:0] key_raw,
  input  logic              halt,
  output logic              core_reset_n,
  output logic [KEY_CH-1:0] key,
  output logic [KEY_CH-1:0] key_pulse,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              running,
  output logic              done,
  output logic              timeout
);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_DONE, ST_TMO} state_t;

  state_t           state, state_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [CNT_W-1:0] cnt_n;
  logic             crn_n, run_n, done_n, tmo_n;

  genvar i;
  generate
    for (i = 0; i < KEY_CH; i++) begin : g_deb
      riscv_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw[i]),
        .key       (key[i]),
        .key_pulse (key_pulse[i])
      );
    end
  endgenerate

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      cycle_cnt    <= '0;
      core_reset_n <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      cycle_cnt    <= cnt_n;
      core_reset_n <= crn_n;
      running      <= run_n;
      done         <= done_n;
      timeout      <= tmo_n;
    end
  end

  // Next state and next output values; DONE/TIMEOUT hold everything.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    cnt_n   = cycle_cnt;
    crn_n   = core_reset_n;
    run_n   = running;
    done_n  = done;
    tmo_n   = timeout;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == HW'(RST_HOLD - 1)) begin
          state_n = ST_RUN;
          hold_n  = '0;
          crn_n   = 1'b1;
          run_n   = 1'b1;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_n = ST_DONE;
          run_n   = 1'b0;
          done_n  = 1'b1;
        end else if (MAX_CYCLES > 0 && cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
          state_n = ST_TMO;
          cnt_n   = CNT_W'(MAX_CYCLES);
          tmo_n   = 1'b1;
          run_n   = 1'b0;
          crn_n   = 1'b0;   // freeze the core
        end else if (cycle_cnt != '1) begin
          cnt_n = cycle_cnt + CNT_W'(1);   // saturate, never wrap
        end
      end
      default: ;
    endcase
`ifdef RUN_CTRL_RESTART_EN
    // Restart beats halt and timeout; ignored while already holding.
    if (key_pulse[0] && state != ST_HOLD) begin
      state_n = ST_HOLD;
      hold_n  = '0;
      cnt_n   = '0;
      crn_n   = 1'b0;
      run_n   = 1'b0;
      done_n  = 1'b0;
      tmo_n   = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: two instances (timeout at 16 with an 8-bit
// counter, and no timeout with a 4-bit saturating counter) share stimulus
// and are compared every cycle against a behavioural model.
module tb_riscv_run_ctrl;
  localparam int KC  = 4;
  localparam int DEB = 8;
  localparam int RH  = 4;
`ifdef RUN_CTRL_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt = 1'b0;
  logic [KC-1:0] key_raw = '0;

  logic a_crn, a_run, a_done, a_tmo;
  logic [KC-1:0] a_key, a_pl;
  logic [7:0] a_cnt;
  logic b_crn, b_run, b_done, b_tmo;
  logic [KC-1:0] b_key, b_pl;
  logic [3:0] b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_run_ctrl #(.KEY_CH(KC), .DEB_CYCLES(DEB), .RST_HOLD(RH), .CNT_W(8), .MAX_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .key_raw(key_raw), .halt(halt),
    .core_reset_n(a_crn), .key(a_key), .key_pulse(a_pl), .cycle_cnt(a_cnt),
    .running(a_run), .done(a_done), .timeout(a_tmo));

  riscv_run_ctrl #(.KEY_CH(KC), .DEB_CYCLES(DEB), .RST_HOLD(RH), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .key_raw(key_raw), .halt(halt),
    .core_reset_n(b_crn), .key(b_key), .key_pulse(b_pl), .cycle_cnt(b_cnt),
    .running(b_run), .done(b_done), .timeout(b_tmo));

  // ---------------- behavioural model ----------------
  // phase: 0 hold, 1 run, 2 done, 3 timeout
  int ph[2], hc[2], cc[2];
  int maxc[2] = '{16, 0};
  int cmax[2] = '{255, 15};
  bit m_s1[KC], m_s2[KC], m_key[KC], m_pl[KC];
  bit hist[KC][DEB];   // most recent synchronised samples, [0] newest
  int nh[KC];          // samples collected since last accepted change

  task automatic model_step(input bit rst, input bit h, input logic [KC-1:0] raw);
    bit kp0;
    bit flip;
    kp0 = m_pl[0];
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        ph[d] = 0; hc[d] = 0; cc[d] = 0;
      end else if (RESTART && kp0 && ph[d] != 0) begin
        ph[d] = 0; hc[d] = 0; cc[d] = 0;
      end else if (ph[d] == 0) begin
        if (hc[d] == RH - 1) begin ph[d] = 1; hc[d] = 0; end
        else hc[d]++;
      end else if (ph[d] == 1) begin
        if (h) ph[d] = 2;
        else if (maxc[d] > 0 && cc[d] == maxc[d] - 1) begin ph[d] = 3; cc[d] = maxc[d]; end
        else if (cc[d] < cmax[d]) cc[d]++;
      end
    end
    for (int c = 0; c < KC; c++) begin
      if (!rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_key[c] = 0; m_pl[c] = 0; nh[c] = 0;
      end else begin
        for (int k = DEB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = m_s2[c];
        if (nh[c] < DEB) nh[c]++;
        // a new level is accepted after DEB consecutive disagreeing samples
        flip = (nh[c] == DEB);
        for (int k = 0; k < DEB; k++) if (hist[c][k] == m_key[c]) flip = 0;
        m_pl[c] = 0;
        if (flip) begin
          m_key[c] = ~m_key[c];
          m_pl[c]  = m_key[c];
          nh[c]    = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  endtask

  function automatic logic [19:0] model_vec(input int d);
    logic [KC-1:0] k, p;
    for (int c = 0; c < KC; c++) begin k[c] = m_key[c]; p[c] = m_pl[c]; end
    return {ph[d] == 1 || ph[d] == 2, ph[d] == 1, ph[d] == 2, ph[d] == 3, k, p, 8'(cc[d])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs are stable from negedge+1 across the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      model_step(reset, halt, key_raw);
      chk("dut_a outputs {crn,run,done,tmo,key,pulse,cnt}",
          {12'h0, a_crn, a_run, a_done, a_tmo, a_key, a_pl, a_cnt}, {12'h0, model_vec(0)});
      chk("dut_b outputs {crn,run,done,tmo,key,pulse,cnt}",
          {12'h0, b_crn, b_run, b_done, b_tmo, b_key, b_pl, 4'h0, b_cnt}, {12'h0, model_vec(1)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic restart_run();
    reset = 1'b0; tick(1); reset = 1'b1; tick(RH);
  endtask

  initial begin
    bit seen;
    // reset state
    tick(3);
    chk("reset core_reset_n", a_crn, 0);
    chk("reset cycle_cnt", a_cnt, 0);
    chk("reset key", a_key, 0);
    chk("reset running", a_run, 0);

    // reset sequencing: core released after edge RST_HOLD
    reset = 1'b1;
    for (int i = 1; i <= RH; i++) begin
      tick(1);
      chk($sformatf("hold edge %0d core_reset_n", i), a_crn, (i == RH));
    end
    chk("run entry running", a_run, 1);
    chk("run entry cycle_cnt", a_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("run count %0d", i), a_cnt, i);
    end

    // halt after 10 run edges, later halts ignored
    tick(7);
    halt = 1'b1; tick(1); halt = 1'b0;
    chk("halt done", a_done, 1);
    chk("halt cycle_cnt", a_cnt, 10);
    chk("halt running", a_run, 0);
    for (int i = 0; i < 21; i++) begin halt = (i % 3 == 0); tick(1); end
    halt = 1'b0;
    chk("done frozen cycle_cnt", a_cnt, 10);
    chk("done stays", a_done, 1);
    chk("done core released", a_crn, 1);

    // timeout at 16; second instance saturates at 15
    restart_run();
    tick(30);
    chk("timeout flag", a_tmo, 1);
    chk("timeout cycle_cnt", a_cnt, 16);
    chk("timeout core_reset_n", a_crn, 0);
    chk("saturated cycle_cnt", b_cnt, 15);
    chk("saturated still running", b_run, 1);

    // halt on the limit edge wins
    restart_run();
    tick(15);
    halt = 1'b1; tick(1); halt = 1'b0;
    chk("halt at limit done", a_done, 1);
    chk("halt at limit timeout", a_tmo, 0);
    chk("halt at limit cycle_cnt", a_cnt, 15);

    // 5-cycle glitch on key 2 is rejected
    seen = 0;
    key_raw[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(1); seen |= a_pl[2]; end
    key_raw[2] = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(1); seen |= a_pl[2]; end
    chk("glitch key", a_key[2], 0);
    chk("glitch pulse", seen, 0);

    // stable press: key rises after edge E+9, one pulse
    key_raw[2] = 1'b1;
    tick(9);
    chk("press key before", a_key[2], 0);
    tick(1);
    chk("press key after", a_key[2], 1);
    chk("press pulse", a_pl[2], 1);
    tick(1);
    chk("press pulse one cycle", a_pl[2], 0);
    // release: no pulse
    key_raw[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(1); seen |= a_pl[2]; end
    chk("release key", a_key[2], 0);
    chk("release pulse", seen, 0);

    // restart from DONE via key 0
    restart_run();
    tick(10);
    halt = 1'b1; tick(1); halt = 1'b0;
    chk("pre-restart cycle_cnt", a_cnt, 10);
    key_raw[0] = 1'b1;
`ifdef RUN_CTRL_RESTART_EN
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(1); seen = a_pl[0]; end
    chk("restart pulse within bound", seen, 1);
    tick(1);
    chk("restart done cleared", a_done, 0);
    chk("restart cycle_cnt", a_cnt, 0);
    chk("restart core_reset_n low", a_crn, 0);
    for (int i = 1; i < RH; i++) begin
      tick(1);
      chk("restart hold core_reset_n", a_crn, 0);
    end
    tick(1);
    chk("restart run core_reset_n", a_crn, 1);
    chk("restart running", a_run, 1);
`else
    tick(20);
    chk("no-restart done", a_done, 1);
    chk("no-restart cycle_cnt", a_cnt, 10);
`endif
    key_raw[0] = 1'b0;
    tick(12);

    // mid-run reset
    restart_run();
    tick(7);
    chk("mid-run cycle_cnt", a_cnt, 7);
    reset = 1'b0; tick(1); reset = 1'b1;
    chk("mid-run reset outputs", {a_crn, a_run, a_done, a_tmo, a_cnt}, 0);
    for (int i = 1; i <= RH; i++) begin
      tick(1);
      chk($sformatf("mid-run hold edge %0d", i), a_crn, (i == RH));
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) != 0);
      halt  = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < KC; c++)
        if ($urandom_range(0, 9) == 0) key_raw[c] = ~key_raw[c];
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
